// File: rtl/z80_exchange_ctrl_if.sv
// z80_exchange_ctrl_if -- signal bundle between the instruction decoder /
// memory port and the exchange-instruction controller.
//
// Handshakes:
//   start/op   : decoder pulse. Taken only when the controller is idle.
//                No ready signal is returned; busy tells the decoder when a
//                new start would be ignored.
//   mem_req/ack: mem_req is a valid-style request. addr/we/wdata stay
//                constant while mem_req is high. mem_ack completes the
//                access in the cycle it is high, and read data is valid
//                with it. mem_req drops or moves to the next access on the
//                following cycle.
//
// Signal groups:
//   decoder side : start, op, sp_in, hl_in -> busy, done, ip_inc
//   register file: de_hl_swap, af_sel, exx_sel, hl_we, hl_wdata
//   memory side  : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   debug        : dbg_state (current FSM state encoding)
interface z80_exchange_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] sp_in;
    logic [15:0] hl_in;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        ip_inc;
    logic        de_hl_swap;
    logic        af_sel;
    logic        exx_sel;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        hl_we;
    logic [15:0] hl_wdata;
    logic [2:0]  dbg_state;

    modport slave (
        input  start, op, sp_in, hl_in, mem_rdata, mem_ack,
        output busy, done, ip_inc, de_hl_swap, af_sel, exx_sel,
               mem_req, mem_we, mem_addr, mem_wdata, hl_we, hl_wdata,
               dbg_state
    );

    modport master (
        output start, op, sp_in, hl_in, mem_rdata, mem_ack,
        input  busy, done, ip_inc, de_hl_swap, af_sel, exx_sel,
               mem_req, mem_we, mem_addr, mem_wdata, hl_we, hl_wdata,
               dbg_state
    );
endinterface

// File: rtl/z80_exchange_ctrl.sv
// z80_exchange_ctrl -- sequencer for the Z80 exchange instructions
// EX DE,HL / EX AF,AF' / EXX (pure bank/name toggles) and EX (SP),HL
// (two reads from the stack followed by two writes, then an HL update).
//
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : z80_exchange_ctrl_if.slave (decoder, register-file and memory
//           signals, plus dbg_state exposing the FSM state)
//
// Timing: accept cycle, four M1 cycles in FETCH, then either FIN directly
// (toggle ops) or four memory states each lasting until mem_ack, then FIN.
module z80_exchange_ctrl (
    input logic               clk,
    input logic               reset,
    z80_exchange_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_RD_LO = 3'd2;
    localparam logic [2:0] S_RD_HI = 3'd3;
    localparam logic [2:0] S_WR_HI = 3'd4;
    localparam logic [2:0] S_WR_LO = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [1:0] OP_EX_DE_HL = 2'b00;
    localparam logic [1:0] OP_EX_AF    = 2'b01;
    localparam logic [1:0] OP_EXX      = 2'b10;
    localparam logic [1:0] OP_EX_SP_HL = 2'b11;

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [7:0] tmp_lo_q, tmp_lo_d;
    logic [7:0] tmp_hi_q, tmp_hi_d;
    logic       de_hl_swap_q, de_hl_swap_d;
    logic       af_sel_q, af_sel_d;
    logic       exx_sel_q, exx_sel_d;

    logic [15:0] sp_plus1;
    assign sp_plus1 = bus.sp_in + 16'd1;   // wraps FFFF -> 0000

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        tmp_lo_d     = tmp_lo_q;
        tmp_hi_d     = tmp_hi_q;
        de_hl_swap_d = de_hl_swap_q;
        af_sel_d     = af_sel_q;
        exx_sel_d    = exx_sel_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    cnt_d   = 3'd1;
                    op_d    = bus.op;
                end
            end
            S_FETCH: begin
                if (cnt_q == 3'd4) begin
                    cnt_d = 3'd0;
                    if (op_q == OP_EX_SP_HL) begin
                        state_d = S_RD_LO;
                    end else begin
                        // Toggle on the FIN-entering edge so the new bank is
                        // already visible during the done cycle.
                        state_d = S_FIN;
                        case (op_q)
                            OP_EX_DE_HL: de_hl_swap_d = ~de_hl_swap_q;
                            OP_EX_AF:    af_sel_d     = ~af_sel_q;
                            OP_EXX:      exx_sel_d    = ~exx_sel_q;
                            default:     ;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RD_LO: begin
                if (bus.mem_ack) begin
                    tmp_lo_d = bus.mem_rdata;
                    state_d  = S_RD_HI;
                end
            end
            S_RD_HI: begin
                if (bus.mem_ack) begin
                    tmp_hi_d = bus.mem_rdata;
                    state_d  = S_WR_HI;
                end
            end
            S_WR_HI: begin
                if (bus.mem_ack) state_d = S_WR_LO;
            end
            S_WR_LO: begin
                if (bus.mem_ack) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            op_q         <= 2'b00;
            tmp_lo_q     <= 8'h00;
            tmp_hi_q     <= 8'h00;
            de_hl_swap_q <= 1'b0;
            af_sel_q     <= 1'b0;
            exx_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            tmp_lo_q     <= tmp_lo_d;
            tmp_hi_q     <= tmp_hi_d;
            de_hl_swap_q <= de_hl_swap_d;
            af_sel_q     <= af_sel_d;
            exx_sel_q    <= exx_sel_d;
        end
    end

    // Memory port is a pure decode of the state so the request stays
    // constant for as long as the controller waits in a memory state.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 8'h00;
        case (state_q)
            S_RD_LO: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.sp_in;
            end
            S_RD_HI: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = sp_plus1;
            end
            S_WR_HI: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = sp_plus1;
                bus.mem_wdata = bus.hl_in[15:8];
            end
            S_WR_LO: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.sp_in;
                bus.mem_wdata = bus.hl_in[7:0];
            end
            default: ;
        endcase
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_FIN);
    assign bus.ip_inc     = (state_q == S_FIN);
    assign bus.hl_we      = (state_q == S_FIN) && (op_q == OP_EX_SP_HL);
    assign bus.hl_wdata   = {tmp_hi_q, tmp_lo_q};
    assign bus.de_hl_swap = de_hl_swap_q;
    assign bus.af_sel     = af_sel_q;
    assign bus.exx_sel    = exx_sel_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_z80_exchange_ctrl.sv
module tb_z80_exchange_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  z80_exchange_ctrl_if bus ();

  z80_exchange_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference state: memory contents and expected select bits
  logic [7:0]  mem [0:65535];
  logic        exp_de = 1'b0;
  logic        exp_af = 1'b0;
  logic        exp_exx = 1'b0;
  logic [15:0] last_hl_wdata = 16'h0000;
  int          hl_we_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_ipinc"}, 32'(bus.ip_inc), 32'd0);
    check({tag, "_memreq"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_hlwe"}, 32'(bus.hl_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_hlwdata"}, 32'(bus.hl_wdata), 32'd0);
    check({tag, "_sels"}, 32'({bus.de_hl_swap, bus.af_sel, bus.exx_sel}), 32'd0);
  endtask

  // One exchange instruction. d0..d3 are ack wait cycles per memory access;
  // spam keeps start high the whole time; abort_wr resets in the first write.
  task automatic run_op(input logic [1:0] op, input logic [15:0] sp, input logic [15:0] hl,
                        input int d0, input int d1, input int d2, input int d3,
                        input bit spam, input bit abort_wr);
    logic [24:0] exp_q[$];
    logic [24:0] cur;
    logic [24:0] want;
    logic [15:0] sp1;
    logic [15:0] exp_hl;
    int dly[4];
    int lat;
    int idx;
    int wcnt;
    bit active;
    bit got_done;
    logic [2:0] sel_before;
    logic [2:0] sel_after;

    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    sp1 = sp + 16'd1;
    exp_hl = {mem[sp1], mem[sp]};
    lat = (op == 2'b11) ? 9 + d0 + d1 + d2 + d3 : 5;
    sel_before = {exp_de, exp_af, exp_exx};
    if (op == 2'b00) exp_de = ~exp_de;
    if (op == 2'b01) exp_af = ~exp_af;
    if (op == 2'b10) exp_exx = ~exp_exx;
    sel_after = {exp_de, exp_af, exp_exx};
    if (op == 2'b11) begin
      exp_q.push_back({1'b0, sp, 8'h00});
      exp_q.push_back({1'b0, sp1, 8'h00});
      exp_q.push_back({1'b1, sp1, hl[15:8]});
      exp_q.push_back({1'b1, sp, hl[7:0]});
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.sp_in = sp;
    bus.hl_in = hl;
    bus.mem_ack = 1'b0;
    @(posedge clk);

    idx = 0; wcnt = 0; active = 1'b0; got_done = 1'b0; cur = '0;
    for (int n = 1; n <= lat + 40; n++) begin
      @(negedge clk);
      if (!spam) bus.start = 1'b0;
      bus.op = 2'($urandom_range(0, 3));   // op must have been latched
      check("busy", 32'(bus.busy), 32'd1);
      if (bus.done) begin
        got_done = 1'b1;
        check("latency", 32'(n), 32'(lat));
        check("ip_inc", 32'(bus.ip_inc), 32'd1);
        check("hl_we_fin", 32'(bus.hl_we), 32'(op == 2'b11));
        if (bus.hl_we) begin
          hl_we_seen++;
          last_hl_wdata = bus.hl_wdata;
          check("hl_wdata", 32'(bus.hl_wdata), 32'(exp_hl));
        end
        check("sel_fin", 32'({bus.de_hl_swap, bus.af_sel, bus.exx_sel}), 32'(sel_after));
        bus.mem_ack = 1'($urandom_range(0, 1));
        break;
      end
      check("ip_inc_idle", 32'(bus.ip_inc), 32'd0);
      check("hl_we_idle", 32'(bus.hl_we), 32'd0);
      check("sel_hold", 32'({bus.de_hl_swap, bus.af_sel, bus.exx_sel}), 32'(sel_before));
      if (bus.mem_req) begin
        if (!active) begin
          active = 1'b1;
          wcnt = 0;
          cur = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00};
          if (exp_q.size() == 0) begin
            check("unexpected_access", 32'(cur), 32'd0);
            want = cur;
          end else begin
            want = exp_q.pop_front();
          end
          check("access", 32'(cur), 32'(want));
          if (abort_wr && bus.mem_we) begin
            reset = 1'b1;
            bus.mem_ack = 1'b0;
            bus.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            check_idle_outputs("abort");
            reset = 1'b0;
            exp_de = 1'b0; exp_af = 1'b0; exp_exx = 1'b0;
            for (int k = 0; k < 8; k++) begin
              @(negedge clk);
              check("abort_no_done", 32'({bus.busy, bus.done, bus.hl_we}), 32'd0);
            end
            return;
          end
        end else begin
          check("req_hold", 32'({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00}), 32'(cur));
        end
        if (idx < 4 && wcnt >= dly[idx]) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = 8'($urandom);
          end else begin
            bus.mem_rdata = mem[bus.mem_addr];
          end
          active = 1'b0;
          idx++;
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_rdata = 8'($urandom);
          wcnt++;
        end
      end else begin
        // acks outside memory states must be ignored
        bus.mem_ack = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
      end
    end
    if (!got_done) check("timeout_done", 32'd0, 32'd1);
    // start may still be high across the FIN edge; it must be ignored
    @(negedge clk);
    bus.start = 1'b0;
    bus.mem_ack = 1'b0;
    check("after_busy", 32'(bus.busy), 32'd0);
    check("after_done", 32'(bus.done), 32'd0);
    check("leftover_access", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int hl_before;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.sp_in = 16'h0000;
    bus.hl_in = 16'h0000;
    bus.mem_rdata = 8'h00;
    bus.mem_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_state", 32'(bus.dbg_state), 32'd0);
    reset = 1'b0;

    // EX DE,HL twice: swap goes 0->1 then 1->0
    run_op(2'b00, 16'h1000, 16'h5678, 0, 0, 0, 0, 1'b0, 1'b0);
    check("de_swap_1", 32'(bus.de_hl_swap), 32'd1);
    run_op(2'b00, 16'h1000, 16'h5678, 0, 0, 0, 0, 1'b0, 1'b0);
    check("de_swap_0", 32'(bus.de_hl_swap), 32'd0);

    // EX (SP),HL across the FFFF/0000 wrap with immediate ack
    mem[16'hFFFF] = 8'hCD;
    mem[16'h0000] = 8'hAB;
    hl_before = hl_we_seen;
    run_op(2'b11, 16'hFFFF, 16'h1234, 0, 0, 0, 0, 1'b0, 1'b0);
    check("wrap_hl_wdata", 32'(last_hl_wdata), 32'h0000ABCD);
    check("wrap_hl_we_once", 32'(hl_we_seen - hl_before), 32'd1);
    check("wrap_mem_0000", 32'(mem[16'h0000]), 32'h12);
    check("wrap_mem_ffff", 32'(mem[16'hFFFF]), 32'h34);

    // three wait cycles per access: 12 cycles later than immediate
    run_op(2'b11, 16'h2000, 16'hBEEF, 3, 3, 3, 3, 1'b0, 1'b0);

    // start held high through EX AF,AF': one toggle, one done
    run_op(2'b01, 16'h0000, 16'h0000, 0, 0, 0, 0, 1'b1, 1'b0);
    check("af_once", 32'(bus.af_sel), 32'd1);
    run_op(2'b10, 16'h0000, 16'h0000, 0, 0, 0, 0, 1'b0, 1'b0);

    // reset in WR_HI aborts and clears selects
    run_op(2'b11, 16'h3000, 16'hCAFE, 1, 0, 2, 0, 1'b0, 1'b1);

    // reset wins over start in the same cycle
    @(negedge clk);
    bus.start = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;
    check("reset_vs_start", 32'(bus.busy), 32'd0);

    // random instruction mix
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [15:0] rsp;
      rop = 2'($urandom_range(0, 3));
      rsp = (i % 8 == 0) ? 16'hFFFF : 16'($urandom);
      run_op(rop, rsp, 16'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z80_exchange_ctrl.md
Z80_EXCHANGE_CTRL -- requirements
Module: z80_exchange_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  decoder pulse: exchange instruction accepted this cycle.
REQ-004 op  in  2  00=EX DE,HL; 01=EX AF,AF'; 10=EXX; 11=EX (SP),HL.
REQ-005 sp_in  in  16  current SP value, stable while busy.
REQ-006 hl_in  in  16  current effective HL, stable while busy.
REQ-007 mem_rdata  in  8  memory read data, valid with mem_ack.
REQ-008 mem_ack  in  1  memory access complete this cycle.
REQ-009 busy  out  1  high from cycle after accept until done cycle inclusive.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 ip_inc  out  1  one-cycle pulse, coincident with done: IP += 1.
REQ-012 de_hl_swap  out  1  DE/HL name-swap flip-flop.
REQ-013 af_sel  out  1  AF/AF' bank select.
REQ-014 exx_sel  out  1  BC/DE/HL main/alternate bank select.
REQ-015 mem_req  out  1  memory access request.
REQ-016 mem_we  out  1  1=write, 0=read; valid while mem_req.
REQ-017 mem_addr  out  16  access address.
REQ-018 mem_wdata  out  8  write data.
REQ-019 hl_we  out  1  one-cycle pulse: write hl_wdata into effective HL.
REQ-020 hl_wdata  out  16  new HL value.

Function
REQ-021 States SHALL be IDLE, FETCH, RD_LO, RD_HI, WR_HI, WR_LO, FIN.
REQ-022 start SHALL be accepted only in IDLE; op latched on accept; start while not IDLE ignored.
REQ-023 On accept: IDLE->FETCH, T-counter=1; counter increments each cycle in FETCH.
REQ-024 FETCH with counter==4: ops 00/01/10 -> FIN; op 11 -> RD_LO; total M1 = 4 cycles.
REQ-025 Entering FIN from ops 00/01/10 SHALL toggle de_hl_swap/af_sel/exx_sel respectively, visible the FIN cycle.
REQ-026 RD_LO: mem_req=1, mem_we=0, mem_addr=sp_in; on mem_ack capture mem_rdata as tmp_lo, ->RD_HI.
REQ-027 RD_HI: read at sp_in+1 (16-bit wrap, FFFF->0000); on mem_ack capture tmp_hi, ->WR_HI.
REQ-028 WR_HI: write hl_in[15:8] to sp_in+1; on mem_ack ->WR_LO.
REQ-029 WR_LO: write hl_in[7:0] to sp_in; on mem_ack ->FIN with hl_we pulse, hl_wdata={tmp_hi,tmp_lo}.
REQ-030 mem_req SHALL hold with constant addr/we/wdata until mem_ack; ack outside memory states ignored; mem_req drops the cycle after ack.
REQ-031 FIN: done=1, ip_inc=1 for exactly one cycle, then IDLE; start in FIN ignored.
REQ-032 Register-only op latency: accept to done = 5 cycles; EX (SP),HL = 5 + total ack-wait cycles (min 4 more with immediate ack).
REQ-033 Select bits SHALL change only per REQ-025 or reset; EX (SP),HL never toggles them.
REQ-034 hl_we SHALL pulse only for op 11.

Reset
REQ-035 reset SHALL force IDLE, counter 0, and all outputs 0 (incl. selects, mem_addr, mem_wdata, hl_wdata) the next cycle.
REQ-036 reset mid-operation SHALL abort: mem_req dropped, no done, no hl_we, no toggle; reset overrides start same cycle.

Verification
REQ-037 op=00 start -> done after 5 cycles, de_hl_swap 0->1; repeat -> 1->0, ip_inc with each done.
REQ-038 op=11, sp_in=FFFF, hl_in=1234, mem holds FFFF=CD, 0000=AB, immediate ack -> reads FFFF,0000; writes 0000=12, FFFF=34; hl_wdata=ABCD, hl_we once.
REQ-039 op=11 with 3-cycle ack delay per access -> request stable during waits, done 12 cycles later than immediate-ack case.
REQ-040 start pulsed every cycle during op=01 -> only one toggle of af_sel, one done.
REQ-041 reset asserted in WR_HI -> mem_req 0 next cycle, no done/hl_we, selects all 0.
